// File: rtl/link_pkg.sv
// Shared link definitions: block framing constants, widths, FSM state
// enum and block classifier. Used by both the receive and transmit sides.
package link_pkg;

  localparam int BLK_W     = 32;
  localparam int PAY_W     = 24;
  localparam int TYPE_W    = 8;
  localparam int CNT_W     = 5;
  localparam int SR_W      = 2 * BLK_W;
  localparam int BAD_LIMIT = 4;
  localparam int BAD_W     = 3;
  localparam int ERR_W     = 8;

  localparam logic [BLK_W-1:0]  SYNC0     = 32'h5555_5555;
  localparam logic [BLK_W-1:0]  SYNC1     = 32'h5555_5554;
  localparam logic [TYPE_W-1:0] TYPE_DATA = 8'hA5;
  localparam logic [TYPE_W-1:0] TYPE_IDLE = 8'h00;
  localparam logic [SR_W-1:0]   SYNC_PAT  = {SYNC0, SYNC1};

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    BLK_DATA = 2'd0,
    BLK_SKIP = 2'd1,
    BLK_BAD  = 2'd2
  } blk_kind_e;

  typedef struct packed {
    logic [PAY_W-1:0]  payload;
    logic [TYPE_W-1:0] btype;
  } blk_t;

  // Sync blocks are matched on all 32 bits; data/idle on the type byte only.
  function automatic blk_kind_e blk_classify(input blk_t b);
    logic [BLK_W-1:0] raw;
    raw = b;
    if (raw == SYNC0 || raw == SYNC1) return BLK_SKIP;
    if (b.btype == TYPE_IDLE)         return BLK_SKIP;
    if (b.btype == TYPE_DATA)         return BLK_DATA;
    return BLK_BAD;
  endfunction

endpackage

// File: rtl/link_rx_sync_detect.sv
// 64-bit sliding-window comparator for the {SYNC0,SYNC1} lock pattern.
// sync_hit flags the cycle whose data_in bit completes the pattern, so the
// FSM locks on that same edge and the next bit is bit 0 of the first block.
module link_rx_sync_detect
  import link_pkg::*;
(
  input  logic clk,
  input  logic res_n,
  input  logic clear,
  input  logic data_in,
  output logic sync_hit
);

  logic [SR_W-1:0] sr_q, sr_d, sr_shift;

  // Window shifts every cycle; clear empties it so no stale bits can match.
  always_comb begin
    sr_shift = {sr_q[SR_W-2:0], data_in};
    sr_d     = clear ? '0 : sr_shift;
  end

  assign sync_hit = !clear && (sr_shift == SYNC_PAT);

  // Window register.
  always_ff @(posedge clk) begin
    if (!res_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

endmodule

// File: rtl/link_rx.sv
// Serial link receiver: hunts for {SYNC0,SYNC1}, then decodes 32-bit blocks
// and presents TYPE_DATA payloads through a 1-entry valid/ready register.
// Optional: define LINK_RX_ERRCNT_EN to add a saturating err_count output.
module link_rx
  import link_pkg::*;
(
  input  logic             clk,
  input  logic             res_n,
  input  logic             cable_connected,
  input  logic             data_in,
  output logic [PAY_W-1:0] rx_data,
  output logic             rx_data_valid,
  input  logic             rx_data_ready,
  output logic             link_locked,
  output logic             rx_overrun
`ifdef LINK_RX_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_count
`endif
);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic [BLK_W-2:0] blk_q, blk_d;
  logic [PAY_W-1:0] hold_q, hold_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             err_inc;
  logic             sync_hit;
  blk_t             blk_now;
  blk_kind_e        kind;
  logic             accept;

  link_rx_sync_detect u_sync (
    .clk      (clk),
    .res_n    (res_n),
    .clear    (!cable_connected),
    .data_in  (data_in),
    .sync_hit (sync_hit)
  );

  assign blk_now = {blk_q, data_in};
  assign kind    = blk_classify(blk_now);
  assign accept  = vld_q && rx_data_ready;

  // Next-state: lock FSM, bit counter, bad-run count and holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    blk_d   = blk_q;
    hold_d  = hold_q;
    vld_d   = vld_q;
    ovr_d   = 1'b0;
    err_inc = 1'b0;

    if (accept) vld_d = 1'b0;

    if (!cable_connected) begin
      // Link gone: drop alignment but keep whatever payload is being held.
      state_d = HUNT;
      cnt_d   = '0;
      bad_d   = '0;
      blk_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            state_d = LOCKED;
            cnt_d   = '0;
            bad_d   = '0;
          end
        end
        LOCKED: begin
          blk_d = blk_now[BLK_W-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLK_W - 1)) begin
            case (kind)
              BLK_DATA: begin
                bad_d = '0;
                // Full register not being drained: drop the new payload.
                if (vld_q && !rx_data_ready) begin
                  ovr_d   = 1'b1;
                  err_inc = 1'b1;
                end else begin
                  hold_d = blk_now.payload;
                  vld_d  = 1'b1;
                end
              end
              BLK_SKIP: bad_d = '0;
              default: begin
                err_inc = 1'b1;
                if (bad_q == BAD_W'(BAD_LIMIT - 1)) begin
                  state_d = HUNT;
                  bad_d   = '0;
                  cnt_d   = '0;
                end else begin
                  bad_d = bad_q + 1'b1;
                end
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      bad_q   <= '0;
      blk_q   <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      blk_q   <= blk_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data       = hold_q;
  assign rx_data_valid = vld_q;
  assign link_locked   = (state_q == LOCKED);
  assign rx_overrun    = ovr_q;

`ifdef LINK_RX_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  // Saturating error count; survives cable drops, cleared only by reset.
  always_comb begin
    err_d = err_q;
    if (err_inc && err_q != '1) err_d = err_q + 1'b1;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!res_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = err_inc;
`endif

endmodule

// File: tb/tb_link_rx.sv
// Scoreboard bench for link_rx: stimulus pushes expected payloads, a negedge
// monitor pops and compares on every accepted rx_data handshake.
module tb_link_rx;
  import link_pkg::*;

  logic clk = 1'b0;
  logic res_n, cable_connected, data_in, rx_data_ready;
  logic [23:0] rx_data;
  logic rx_data_valid, link_locked, rx_overrun;
`ifdef LINK_RX_ERRCNT_EN
  logic [7:0] err_count;
  int exp_err = 0;
`endif

  int checks = 0;
  int fails  = 0;
  int ovr_seen = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  link_rx dut (
    .clk             (clk),
    .res_n           (res_n),
    .cable_connected (cable_connected),
    .data_in         (data_in),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .rx_data_ready   (rx_data_ready),
    .link_locked     (link_locked),
    .rx_overrun      (rx_overrun)
`ifdef LINK_RX_ERRCNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bit; returns just after the edge that sampled it.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send the top n bits of w, MSB first.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
  endtask

  task automatic send_sync();
    send_word(SYNC0);
    send_word(SYNC1);
  endtask

  // Monitor: every accepted payload must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [23:0] e;
    if (res_n && rx_data_valid && rx_data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL pop: unexpected payload %h with empty queue", rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("payload", {8'h0, rx_data}, {8'h0, e});
      end
    end
    if (rx_overrun) ovr_seen++;
  end

  initial begin
    logic [31:0] w;
    res_n = 1'b0; cable_connected = 1'b1; data_in = 1'b0; rx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, rx_data_valid}, 0);
    chk("rst_data", {8'h0, rx_data}, 0);
    chk("rst_locked", {31'h0, link_locked}, 0);
    chk("rst_overrun", {31'h0, rx_overrun}, 0);
`ifdef LINK_RX_ERRCNT_EN
    chk("rst_err", {24'h0, err_count}, 0);
`endif
    res_n = 1'b1;

    // Near-miss sync pattern must not lock.
    send_word(SYNC0);
    send_word(32'h5555_5556);
    chk("nearmiss_locked", {31'h0, link_locked}, 0);
    send_bits(32'h0, 8);
    chk("nearmiss_locked2", {31'h0, link_locked}, 0);
    chk("nearmiss_valid", {31'h0, rx_data_valid}, 0);

    // Sync then one data block with ready high.
    send_word(SYNC0);
    w = SYNC1;
    send_bits(w, 31);
    chk("lock_before_last", {31'h0, link_locked}, 0);
    send_bit(w[0]);
    chk("lock_after_sync", {31'h0, link_locked}, 1);
    exp_q.push_back(24'h000001);
    send_word({24'h000001, TYPE_DATA});
    chk("data1_valid", {31'h0, rx_data_valid}, 1);
    chk("data1_value", {8'h0, rx_data}, 32'h000001);
    send_bit(1'b0);
    chk("data1_valid_drop", {31'h0, rx_data_valid}, 0);
    send_bits(32'h0, 31);

    // Backpressure: second block overruns and is dropped.
    rx_data_ready = 1'b0;
    exp_q.push_back(24'h000002);
    send_word({24'h000002, TYPE_DATA});
    send_word({24'h000003, TYPE_DATA});
`ifdef LINK_RX_ERRCNT_EN
    exp_err++;
`endif
    chk("bp_overrun", {31'h0, rx_overrun}, 1);
    chk("bp_hold", {8'h0, rx_data}, 32'h000002);
    chk("bp_valid", {31'h0, rx_data_valid}, 1);
    rx_data_ready = 1'b1;
    send_bit(1'b0);
    chk("bp_overrun_pulse", {31'h0, rx_overrun}, 0);
    chk("bp_drained", {31'h0, rx_data_valid}, 0);
    send_bits(32'h0, 31);

    // Accept and new payload on the same edge: no overrun, valid stays high.
    rx_data_ready = 1'b0;
    exp_q.push_back(24'h000004);
    send_word({24'h000004, TYPE_DATA});
    w = {24'h000005, TYPE_DATA};
    send_bits(w, 31);
    rx_data_ready = 1'b1;
    exp_q.push_back(24'h000005);
    send_bit(w[0]);
    chk("simul_valid", {31'h0, rx_data_valid}, 1);
    chk("simul_data", {8'h0, rx_data}, 32'h000005);
    chk("simul_no_ovr", {31'h0, rx_overrun}, 0);
    send_word(32'h0);

    // Three bad blocks then idle: stays locked.
    for (int i = 0; i < 3; i++) send_word({24'h0, 8'h7E});
    send_word(32'h0);
    chk("bad3_locked", {31'h0, link_locked}, 1);
    // Four bad blocks: back to HUNT after the fourth.
    for (int i = 0; i < 3; i++) send_word({24'h0, 8'h7E});
    chk("bad3b_locked", {31'h0, link_locked}, 1);
    send_word({24'h0, 8'h7E});
    chk("bad4_unlocked", {31'h0, link_locked}, 0);
`ifdef LINK_RX_ERRCNT_EN
    exp_err += 7;
    chk("err_count_bad", {24'h0, err_count}, exp_err);
`endif

    // Cable drop mid-block keeps the held payload, then relock.
    send_sync();
    chk("relock1", {31'h0, link_locked}, 1);
    rx_data_ready = 1'b0;
    exp_q.push_back(24'h123456);
    send_word({24'h123456, TYPE_DATA});
    send_bits(32'hFFFF_FFFF, 10);
    cable_connected = 1'b0;
    send_bit(1'b1);
    cable_connected = 1'b1;
    chk("cable_unlocked", {31'h0, link_locked}, 0);
    chk("cable_hold_valid", {31'h0, rx_data_valid}, 1);
    chk("cable_hold_data", {8'h0, rx_data}, 32'h123456);
    rx_data_ready = 1'b1;
    send_sync();
    chk("relock2", {31'h0, link_locked}, 1);
    exp_q.push_back(24'hABCDEF);
    send_word({24'hABCDEF, TYPE_DATA});
    chk("cable_data_valid", {31'h0, rx_data_valid}, 1);
    chk("cable_data_value", {8'h0, rx_data}, 32'hABCDEF);
    send_word(32'h0);
`ifdef LINK_RX_ERRCNT_EN
    chk("err_after_cable", {24'h0, err_count}, exp_err);
`endif

    // Reset mid-handshake discards the held payload silently.
    rx_data_ready = 1'b0;
    send_word({24'h777777, TYPE_DATA});
    chk("pre_rst_valid", {31'h0, rx_data_valid}, 1);
    res_n = 1'b0;
    send_bit(1'b0);
    res_n = 1'b1;
    chk("midrst_valid", {31'h0, rx_data_valid}, 0);
    chk("midrst_data", {8'h0, rx_data}, 0);
    chk("midrst_locked", {31'h0, link_locked}, 0);
    chk("midrst_overrun", {31'h0, rx_overrun}, 0);
`ifdef LINK_RX_ERRCNT_EN
    chk("midrst_err", {24'h0, err_count}, 0);
`endif
    send_bits(32'h0, 4);

    chk("overrun_pulses", ovr_seen, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/link_rx.md
LINK_RX -- requirements
Module: link_rx

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: res_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: cable_connected  input  1  link-present qualifier.
REQ-004 SHALL have port: data_in  input  1  serial line, one bit per clk, MSB first.
REQ-005 SHALL have port: rx_data  output  24  received payload.
REQ-006 SHALL have port: rx_data_valid  output  1  payload held in rx_data.
REQ-007 SHALL have port: rx_data_ready  input  1  consumer accepts payload.
REQ-008 SHALL have port: link_locked  output  1  block alignment achieved.
REQ-009 SHALL have port: rx_overrun  output  1  one-cycle pulse; payload dropped.

Function
REQ-010 Block format SHALL be 32 bits {payload[23:0], type[7:0]}: SYNC0 = 0x55555555, SYNC1 = 0x55555554, TYPE_DATA = 0xA5, TYPE_IDLE = 0x00.
REQ-011 FSM states SHALL be HUNT, LOCKED.
REQ-012 HUNT: 64-bit shift register loads data_in every cycle; when it equals {SYNC0,SYNC1}, the FSM SHALL enter LOCKED on the next edge, with the bit counter at 0.
REQ-013 LOCKED: a 5-bit counter SHALL count 0..31 and wrap; the block SHALL be decoded in the cycle in which bit 31 is sampled.
REQ-014 TYPE_DATA block: payload SHALL be loaded into a 1-entry holding register; rx_data_valid SHALL rise exactly 1 cycle after the last bit is sampled.
REQ-015 rx_data/rx_data_valid SHALL be held stable until a cycle with rx_data_valid && rx_data_ready; valid SHALL drop after that cycle unless a new payload loads in the same cycle.
REQ-016 A new TYPE_DATA block arriving while valid && !ready SHALL be dropped, leaving the old payload held, and rx_overrun SHALL pulse 1 cycle.
REQ-017 Simultaneous accept and new payload SHALL load the new payload with valid held high and no overrun.
REQ-018 TYPE_IDLE, SYNC0 and SYNC1 blocks in LOCKED SHALL be discarded silently.
REQ-019 Any other type SHALL be a bad block; 4 consecutive bad blocks SHALL return the FSM to HUNT, and any good block SHALL clear the run count.
REQ-020 link_locked SHALL equal (state == LOCKED).
REQ-021 cable_connected low SHALL force HUNT on the next edge, clear the shift register, counter and bad-run count, and keep the holding register contents.

Reset
REQ-022 res_n low at a rising edge SHALL set: state HUNT, all counters 0, shift register 0, rx_data 0, rx_data_valid 0, link_locked 0, rx_overrun 0.
REQ-023 Reset mid-block or mid-handshake SHALL discard the partial block and any held payload without pulsing rx_overrun.

Configuration
REQ-024 Macro LINK_RX_ERRCNT_EN defined: the block SHALL add output err_count [7:0], a saturating-at-255 count of bad blocks and overruns, reset to 0 and not cleared by cable_connected.
REQ-025 Macro LINK_RX_ERRCNT_EN undefined: err_count port and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package link_pkg SHALL hold SYNC0, SYNC1, TYPE_DATA, TYPE_IDLE, the block and payload width constants, the bad-run limit (4) and the FSM state enum; the transmit side SHALL share the same package.
REQ-027 The 64-bit sync comparator SHALL be a sub-module link_rx_sync_detect (inputs clk, res_n, clear, data_in; output sync_hit).

Verification
REQ-028 Sync then data: serial SYNC0, SYNC1, then {0x000001,0xA5}, ready=1 -> link_locked rises after SYNC1; rx_data=0x000001, valid for 1 cycle, 1 cycle after the 32nd data bit.
REQ-029 Backpressure: ready=0, two data blocks 0x000002, 0x000003 -> rx_data stays 0x000002; rx_overrun pulses once at the second block end; ready=1 then drains 0x000002 only.
REQ-030 Idle and bad runs: 3 blocks of type 0x7E then 1 idle -> stays locked; 4 blocks of type 0x7E -> link_locked=0 after the 4th, and err_count=4 with LINK_RX_ERRCNT_EN.
REQ-031 Cable drop: cable_connected=0 for 1 cycle mid-block -> HUNT next edge; the next {SYNC0,SYNC1} relocks, and the following data block is received correctly.
REQ-032 Reset mid-handshake: valid=1, ready=0, res_n=0 for 1 cycle -> valid=0, rx_data=0, link_locked=0, no overrun pulse.
REQ-033 Near-miss sync: SYNC0 followed by 0x55555556 -> remains HUNT, no valid.
